uart_pkt_rx: RTL and testbench
==============================

Name: uart_pkt_rx

Overview:
- Framing stage directly downstream of uart_rx; consumes its rx_data_o/rx_valid_o stream and drives its rx_ready_i.
- Hunts for a start-of-frame byte, then captures length, payload and checksum.
- Buffers the payload and releases it on a valid/ready/last stream only after the checksum verifies.
- Reports per-packet success or error for the core's UART command path (e.g. tx1/rx1 link).

Parameters:
MAX_LEN  16     maximum payload bytes per packet (1..255)
SOF      8'hA5  start-of-frame byte value

Ports:
clk_i          in   1   system clock
rstn_i         in   1   reset, asynchronous, active-low
rx_data_i      in   8   byte from uart_rx.rx_data_o
rx_valid_i     in   1   byte valid, from uart_rx.rx_valid_o
rx_ready_o     out  1   byte accept, to uart_rx.rx_ready_i
timeout_i      in   16  inter-byte timeout in clk cycles; 0 = disabled
m_data_o       out  8   payload byte
m_valid_o      out  1   payload valid
m_last_o       out  1   marks final payload byte
m_ready_i      in   1   downstream accept
pkt_ok_o       out  1   1-cycle pulse: packet verified
pkt_err_o      out  1   1-cycle pulse: packet dropped
err_code_o     out  2   cause of last drop (held until next drop): 1 BADLEN, 2 CHKSUM, 3 TIMEOUT

Behaviour:
- Reset (async, rstn_i low): state IDLE; rx_ready_o=1; m_valid_o, m_last_o, pkt_ok_o, pkt_err_o, err_code_o, m_data_o, length, index, checksum and timer all 0.
- A byte is accepted on a cycle with rx_valid_i & rx_ready_o. rx_ready_o=1 in IDLE/LEN/PAYLOAD/CHK and 0 in DRAIN, back-pressuring uart_rx.
- IDLE: accepted byte == SOF -> LEN. Other bytes are discarded silently with no error.
- LEN:
  - byte 0 or byte > MAX_LEN -> pkt_err_o pulse, err_code=1 -> IDLE.
  - otherwise store len, chk=byte, idx=0 -> PAYLOAD.
- PAYLOAD: each byte is written to buf[idx], chk ^= byte, idx++. When idx reaches len-1 on acceptance -> CHK. A SOF value inside the payload is ordinary data.
- CHK:
  - byte == chk -> pkt_ok_o pulse, idx=0 -> DRAIN.
  - else pkt_err_o pulse, err_code=2 -> IDLE.
- DRAIN:
  - m_valid_o=1 from the cycle after the checksum byte is accepted (1-cycle latency).
  - m_data_o=buf[idx]; m_last_o=(idx==len-1).
  - On m_valid_o & m_ready_i: idx++.
  - On the last handshake: m_valid_o=0 next cycle -> IDLE.
  - m_data_o holds stable while m_valid_o & !m_ready_i.
- Timer:
  - Counts cycles in LEN/PAYLOAD/CHK and clears on every accepted byte and on entry to IDLE/DRAIN.
  - When timeout_i!=0 and timer==timeout_i-1 with no byte accepted that cycle: pkt_err_o pulse, err_code=3 -> IDLE.
  - A byte accepted in the same cycle the timer expires wins; no timeout fires.
  - timeout_i==0 disables the timer; never idle in DRAIN.
- pkt_ok_o and pkt_err_o are never high together. err_code_o updates only with pkt_err_o.
- Widths: len/idx are $clog2(MAX_LEN+1) bits; chk is 8-bit XOR of LEN and all payload bytes.
- Reset mid-packet or mid-drain discards everything and returns to IDLE with outputs at reset values.

Decomposition:
- Package uart_pkt_pkg:
  - state enum {IDLE, LEN, PAYLOAD, CHK, DRAIN}.
  - err enum {ERR_NONE=0, ERR_BADLEN=1, ERR_CHKSUM=2, ERR_TIMEOUT=3}.
  - Default SOF constant.
- Sub-module uart_pkt_buf: MAX_LEN x 8 register file, one write port and one asynchronous read port, no reset on storage.

Test Plan:
- Send A5 03 11 22 33 03 with m_ready_i=1 -> pkt_ok_o pulse; stream 11, 22, 33 with m_last_o on 33; no pkt_err_o.
- Send 00 FF A5 01 5A 5B -> leading 00 FF ignored silently; pkt_ok_o; single byte 5A with m_last_o=1.
- Send A5 02 10 20 00 (correct chk 32) -> pkt_err_o, err_code_o=2, m_valid_o stays 0. Then A5 01 A5 A4 -> ok, outputs A5.
- Send A5 00, then A5 11 with MAX_LEN=16 -> two pkt_err_o pulses, err_code_o=1 each; state back to IDLE.
- timeout_i=100: send A5 03 11, then idle 100 cycles -> pkt_err_o on the 100th idle cycle, err_code_o=3. Also: a byte arriving exactly at expiry is accepted.
- Packet A5 03 11 22 33 03 with m_ready_i toggling 1-0-0-1; an extra byte offered during DRAIN -> rx_ready_o=0 until after the last beat; data held stable while stalled.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet framing receiver.
package uart_pkt_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADLEN  = 2'd1,
    ERR_CHKSUM  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store: DEPTH x 8 register file, one write port, one asynchronous read port.
module uart_pkt_buf
  import uart_pkt_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];

  // Addresses at or beyond DEPTH are ignored on write and read back as zero.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < AW'(DEPTH))) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i < AW'(DEPTH)) ? mem_q[raddr_i[IW-1:0]] : '0;

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet framer behind uart_rx: SOF hunt, length/payload/checksum capture,
// payload released on a valid/ready/last stream only after the checksum verifies.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int unsigned       MAX_LEN = 16,
  parameter logic [BYTE_W-1:0] SOF     = SOF_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [15:0]       timeout_i,
  output logic [BYTE_W-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              pkt_ok_o,
  output logic              pkt_err_o,
  output logic [1:0]        err_code_o
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = 16;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [BYTE_W-1:0] chk_q, chk_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              rx_ready_q, rx_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [BYTE_W-1:0] m_data_q, m_data_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic              pkt_err_q, pkt_err_d;
  err_e              err_code_q, err_code_d;

  logic              acc;
  logic              len_ok;
  logic              tmo_hit;
  logic              beat;
  logic              buf_we;
  logic [BYTE_W-1:0] buf_rdata;

  assign acc     = rx_valid_i & rx_ready_q;
  assign beat    = m_valid_q & m_ready_i;
  assign len_ok  = (rx_data_i != '0) && (rx_data_i <= BYTE_W'(MAX_LEN));
  // An accepted byte in the expiry cycle takes priority over the timeout.
  assign tmo_hit = (timeout_i != '0) && (timer_q == (timeout_i - TW'(1))) && !acc;

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (rx_data_i),
    .raddr_i (idx_d),
    .rdata_o (buf_rdata)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    timer_d    = timer_q;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (acc && (rx_data_i == SOF)) begin
          state_d = LEN;
        end
      end

      LEN: begin
        if (acc) begin
          timer_d = '0;
          if (!len_ok) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_BADLEN;
            state_d    = IDLE;
          end else begin
            len_d   = LW'(rx_data_i);
            chk_d   = rx_data_i;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end else if (tmo_hit) begin
          timer_d    = '0;
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      PAYLOAD: begin
        if (acc) begin
          timer_d = '0;
          buf_we  = 1'b1;
          chk_d   = chk_q ^ rx_data_i;
          idx_d   = idx_q + LW'(1);
          if (idx_q == (len_q - LW'(1))) begin
            state_d = CHK;
          end
        end else if (tmo_hit) begin
          timer_d    = '0;
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      CHK: begin
        if (acc) begin
          timer_d = '0;
          if (rx_data_i == chk_q) begin
            pkt_ok_d = 1'b1;
            idx_d    = '0;
            state_d  = DRAIN;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_CHKSUM;
            state_d    = IDLE;
          end
        end else if (tmo_hit) begin
          timer_d    = '0;
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      DRAIN: begin
        timer_d = '0;
        if (beat) begin
          if (m_last_q) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + LW'(1);
          end
        end
      end

      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    // Stream outputs follow the next state, giving one cycle of latency after the checksum.
    rx_ready_d = (state_d != DRAIN);
    m_valid_d  = (state_d == DRAIN);
    m_last_d   = (state_d == DRAIN) && (idx_d == (len_q - LW'(1)));
    m_data_d   = (state_d == DRAIN) ? buf_rdata : m_data_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      timer_q    <= '0;
      rx_ready_q <= 1'b1;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      timer_q    <= timer_d;
      rx_ready_q <= rx_ready_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_err_q  <= pkt_err_d;
      err_code_q <= err_code_d;
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign m_valid_o  = m_valid_q;
  assign m_last_o   = m_last_q;
  assign m_data_o   = m_data_q;
  assign pkt_ok_o   = pkt_ok_q;
  assign pkt_err_o  = pkt_err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed testbench for uart_pkt_rx with hand-computed packets and checksums.
module tb_uart_pkt_rx;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [15:0] timeout_i;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_i;
  logic        pkt_ok_o;
  logic        pkt_err_o;
  logic [1:0]  err_code_o;

  int errors = 0;
  int checks = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;
  logic [7:0] cap_data[$];
  logic       cap_last[$];

  uart_pkt_rx #(.MAX_LEN(16), .SOF(8'hA5)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .timeout_i  (timeout_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i),
    .pkt_ok_o   (pkt_ok_o),
    .pkt_err_o  (pkt_err_o),
    .err_code_o (err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe stream beats and status pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rstn && m_valid_o && m_ready_i) begin
      cap_data.push_back(m_data_o);
      cap_last.push_back(m_last_o);
    end
    if (pkt_ok_o === 1'b1) ok_cnt++;
    if (pkt_err_o === 1'b1) err_cnt++;
    if (pkt_ok_o === 1'b1 && pkt_err_o === 1'b1) both_seen = 1'b1;
  end

  // Offer one byte and return #1 after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   done;
    done = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rdy = rx_ready_o;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    rx_valid_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_byte_timeout: byte %02h not accepted, rx_ready_o=%b required 1", b, rx_ready_o);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rstn       = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    m_ready_i  = 1'b1;
    timeout_i  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_ready_o !== 1'b1 || m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== 8'h00 ||
        pkt_ok_o !== 1'b0 || pkt_err_o !== 1'b0 || err_code_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b last=%b data=%02h ok=%b err=%b code=%0d required 1 0 0 00 0 0 0",
               rx_ready_o, m_valid_o, m_last_o, m_data_o, pkt_ok_o, pkt_err_o, err_code_o);
    end
    rstn = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_basic;
    logic [7:0] exp [3];
    int e0;
    exp = '{8'h11, 8'h22, 8'h33};
    cap_data.delete(); cap_last.delete();
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h03);
    checks++;
    if (pkt_ok_o !== 1'b1 || m_valid_o !== 1'b1 || m_data_o !== 8'h11) begin
      errors++;
      $display("FAIL basic_ok_latency: ok=%b vld=%b data=%02h required 1 1 11", pkt_ok_o, m_valid_o, m_data_o);
    end
    idle_cycles(8);
    checks++;
    if (cap_data.size() != 3) begin
      errors++;
      $display("FAIL basic_count: beats=%0d required 3", cap_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < cap_data.size()) begin
        checks++;
        if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 2)) begin
          errors++;
          $display("FAIL basic_beat%0d: data=%02h last=%b required %02h %b", i, cap_data[i], cap_last[i], exp[i], (i == 2));
        end
      end
    end
    checks++;
    if (err_cnt != e0 || rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_no_err: err pulses=%0d rdy=%b required 0 1", err_cnt - e0, rx_ready_o);
    end
  endtask

  task automatic test_sof_hunt;
    int e0;
    cap_data.delete(); cap_last.delete();
    e0 = err_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
    checks++;
    if (pkt_ok_o !== 1'b1) begin
      errors++;
      $display("FAIL sof_ok: ok=%b required 1", pkt_ok_o);
    end
    idle_cycles(5);
    checks++;
    if (cap_data.size() != 1 || (cap_data.size() == 1 && (cap_data[0] !== 8'h5A || cap_last[0] !== 1'b1))) begin
      errors++;
      $display("FAIL sof_stream: beats=%0d first=%02h required 1 beat 5A last", cap_data.size(),
               (cap_data.size() > 0) ? cap_data[0] : 8'hxx);
    end
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL sof_silent: err pulses=%0d required 0", err_cnt - e0);
    end
  endtask

  task automatic test_chksum;
    int o0;
    cap_data.delete(); cap_last.delete();
    o0 = ok_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    checks++;
    if (pkt_err_o !== 1'b1 || err_code_o !== 2'd2) begin
      errors++;
      $display("FAIL chk_err: err=%b code=%0d required 1 2", pkt_err_o, err_code_o);
    end
    idle_cycles(5);
    checks++;
    if (cap_data.size() != 0 || ok_cnt != o0 || m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL chk_no_stream: beats=%0d ok pulses=%0d vld=%b required 0 0 0", cap_data.size(), ok_cnt - o0, m_valid_o);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA4);
    checks++;
    if (pkt_ok_o !== 1'b1 || m_data_o !== 8'hA5 || m_last_o !== 1'b1) begin
      errors++;
      $display("FAIL chk_sof_payload: ok=%b data=%02h last=%b required 1 A5 1", pkt_ok_o, m_data_o, m_last_o);
    end
    idle_cycles(3);
  endtask

  task automatic test_badlen;
    int e0;
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    checks++;
    if (pkt_err_o !== 1'b1 || err_code_o !== 2'd1) begin
      errors++;
      $display("FAIL badlen_zero: err=%b code=%0d required 1 1", pkt_err_o, err_code_o);
    end
    idle_cycles(1);
    send_byte(8'hA5); send_byte(8'h11);
    checks++;
    if (pkt_err_o !== 1'b1 || err_code_o !== 2'd1) begin
      errors++;
      $display("FAIL badlen_17: err=%b code=%0d required 1 1", pkt_err_o, err_code_o);
    end
    idle_cycles(2);
    checks++;
    if (err_cnt - e0 != 2 || rx_ready_o !== 1'b1 || err_code_o !== 2'd1) begin
      errors++;
      $display("FAIL badlen_pulses: pulses=%0d rdy=%b code=%0d required 2 1 1", err_cnt - e0, rx_ready_o, err_code_o);
    end
  endtask

  task automatic test_maxlen;
    cap_data.delete(); cap_last.delete();
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h00);
    checks++;
    if (pkt_ok_o !== 1'b1) begin
      errors++;
      $display("FAIL maxlen_ok: ok=%b required 1", pkt_ok_o);
    end
    idle_cycles(20);
    checks++;
    if (cap_data.size() != 16) begin
      errors++;
      $display("FAIL maxlen_count: beats=%0d required 16", cap_data.size());
    end
    for (int i = 0; i < 16; i++) begin
      if (i < cap_data.size()) begin
        checks++;
        if (cap_data[i] !== 8'(i + 1) || cap_last[i] !== (i == 15)) begin
          errors++;
          $display("FAIL maxlen_beat%0d: data=%02h last=%b required %02h %b", i, cap_data[i], cap_last[i], 8'(i + 1), (i == 15));
        end
      end
    end
  endtask

  task automatic test_timeout;
    int e0;
    int early;
    timeout_i = 16'd100;
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    early = 0;
    for (int i = 0; i < 99; i++) begin
      @(posedge clk);
      #1;
      if (pkt_err_o === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: err pulses before expiry=%0d required 0", early);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pkt_err_o !== 1'b1 || err_code_o !== 2'd3) begin
      errors++;
      $display("FAIL timeout_fire: err=%b code=%0d required 1 3", pkt_err_o, err_code_o);
    end
    idle_cycles(2);
    // Byte offered so that it lands on the expiry cycle: acceptance must win.
    cap_data.delete(); cap_last.delete();
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    idle_cycles(99);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    checks++;
    if (pkt_ok_o !== 1'b1 || err_cnt != e0) begin
      errors++;
      $display("FAIL timeout_race: ok=%b err pulses=%0d required 1 0", pkt_ok_o, err_cnt - e0);
    end
    idle_cycles(5);
    checks++;
    if (cap_data.size() != 3 || (cap_data.size() == 3 && (cap_data[1] !== 8'h22 || cap_last[2] !== 1'b1))) begin
      errors++;
      $display("FAIL timeout_race_stream: beats=%0d required 3 (11 22 33)", cap_data.size());
    end
    timeout_i = 16'd0;
  endtask

  task automatic test_backpressure;
    bit pat [4];
    int k;
    int rdy_viol;
    int stable_viol;
    bit stalled;
    logic [7:0] prev;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cap_data.delete(); cap_last.delete();
    m_ready_i = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h03);
    k = 0; rdy_viol = 0; stable_viol = 0; stalled = 1'b0; prev = 8'h00;
    while (m_valid_o === 1'b1 && k < 40) begin
      if (rx_ready_o !== 1'b0) rdy_viol++;
      if (stalled && m_data_o !== prev) stable_viol++;
      m_ready_i  = pat[k % 4];
      rx_data_i  = 8'h77;
      rx_valid_i = 1'b1;
      prev    = m_data_o;
      stalled = !m_ready_i;
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k != 5 || rdy_viol != 0) begin
      errors++;
      $display("FAIL bp_drain: drain cycles=%0d rdy while draining=%0d required 5 0", k, rdy_viol);
    end
    checks++;
    if (stable_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: data changes while stalled=%0d required 0", stable_viol);
    end
    checks++;
    if (rx_ready_o !== 1'b1 || m_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b required 1 0", rx_ready_o, m_valid_o);
    end
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    m_ready_i  = 1'b1;
    checks++;
    if (cap_data.size() != 3 ||
        (cap_data.size() == 3 && (cap_data[0] !== 8'h11 || cap_data[1] !== 8'h22 || cap_data[2] !== 8'h33 ||
                                  cap_last[1] !== 1'b0 || cap_last[2] !== 1'b1))) begin
      errors++;
      $display("FAIL bp_stream: beats=%0d required 11 22 33 with last on 33", cap_data.size());
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid;
    cap_data.delete(); cap_last.delete();
    m_ready_i = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
    idle_cycles(2);
    checks++;
    if (m_valid_o !== 1'b1 || rx_ready_o !== 1'b0 || m_data_o !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_draining: vld=%b rdy=%b data=%02h required 1 0 5A", m_valid_o, rx_ready_o, m_data_o);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (m_valid_o !== 1'b0 || rx_ready_o !== 1'b1 || m_data_o !== 8'h00 || m_last_o !== 1'b0 || err_code_o !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_values: vld=%b rdy=%b data=%02h last=%b code=%0d required 0 1 00 0 0",
               m_valid_o, rx_ready_o, m_data_o, m_last_o, err_code_o);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_ready_i = 1'b1;
    idle_cycles(1);
    cap_data.delete(); cap_last.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hFD);
    idle_cycles(4);
    checks++;
    if (cap_data.size() != 2 || (cap_data.size() == 2 && (cap_data[0] !== 8'hC3 || cap_data[1] !== 8'h3C))) begin
      errors++;
      $display("FAIL rstmid_after: beats=%0d required C3 3C", cap_data.size());
    end
    checks++;
    if (both_seen) begin
      errors++;
      $display("FAIL ok_err_exclusive: both pulses seen together=%b required 0", both_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sof_hunt();
    test_chksum();
    test_badlen();
    test_maxlen();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
